// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared widths, helpers and pipeline tag type for the   |
// |               mem_port_arbiter block.                                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_N_RD = 3;

  // Writer sits at index N_RD, after all readers.
  function automatic int f_nreq(input int n_rd);
    return n_rd + 1;
  endfunction

  function automatic int f_lsb(input int data_w);
    return $clog2(data_w) - 3;
  endfunction

  function automatic int f_aw(input int byte_addr_w, input int data_w);
    return byte_addr_w - f_lsb(data_w);
  endfunction

  localparam int TAG_IDX_W = $clog2(f_nreq(DEF_N_RD));

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
    logic                 is_read;
  } arb_tag_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin arbiter with last-grant ptr.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]  i_req,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Search begins just after the last winner so every requester is served in turn.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    if (rstn) begin
      for (int k = 1; k <= NREQ; k++) begin
        w_cand = IDX_W'((int'(r_ptr) + k) % NREQ);
        if (!w_found && i_req[w_cand]) begin
          w_found        = 1'b1;
          o_gnt[w_cand]  = 1'b1;
          o_gnt_idx      = w_cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr <= IDX_W'(NREQ - 1);
    end else if (w_found) begin
      r_ptr <= o_gnt_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one single-port word memory between N_RD   |
// |   readers and one writer; optional counters via MEM_ARB_PERF_EN.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int AXI_WIDTH      = 128,
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int N_RD           = 3,
  localparam int AW             = f_aw(AXI_ADDR_WIDTH, AXI_WIDTH),
  localparam int SW             = AXI_WIDTH / 8,
  localparam int NREQ           = f_nreq(N_RD)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_RD-1:0]           rd_req,
  input  logic [N_RD*AW-1:0]        rd_addr,
  output logic [N_RD-1:0]           rd_gnt,
  output logic [N_RD-1:0]           rd_rvalid,
  output logic [N_RD*AXI_WIDTH-1:0] rd_data,
  input  logic                      wr_req,
  input  logic [AW-1:0]             wr_addr,
  input  logic [AXI_WIDTH-1:0]      wr_data,
  input  logic [SW-1:0]             wr_strb,
  output logic                      wr_gnt,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [AXI_WIDTH-1:0]      mem_wdata,
  output logic [SW-1:0]             mem_strb,
`ifdef MEM_ARB_PERF_EN
  output logic [NREQ*32-1:0]        perf_gnt_cnt,
  output logic [NREQ*32-1:0]        perf_wait_cnt,
`endif
  input  logic [AXI_WIDTH-1:0]      mem_rdata
);

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]          w_req;
  logic [NREQ-1:0]          w_gnt;
  logic [IDX_W-1:0]         w_gnt_idx;
  logic                     w_any_gnt;
  logic                     w_is_wr;
  logic [AW-1:0]            w_sel_addr;

  logic                     r_mem_en;
  logic                     r_mem_we;
  logic [AW-1:0]            r_mem_addr;
  logic [AXI_WIDTH-1:0]     r_mem_wdata;
  logic [SW-1:0]            r_mem_strb;
  arb_tag_t                 r_tag_cmd;
  arb_tag_t                 r_tag_ret;
  logic [N_RD-1:0]          r_rd_rvalid;
  logic [N_RD*AXI_WIDTH-1:0] r_rd_data;

  assign w_req = {wr_req, rd_req};

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rstn      (rstn),
    .i_req     (w_req),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_any_gnt = |w_gnt;
  assign w_is_wr   = w_gnt[N_RD];
  assign rd_gnt    = w_gnt[N_RD-1:0];
  assign wr_gnt    = w_gnt[N_RD];

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < N_RD; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = rd_addr[i*AW +: AW];
      end
    end
    if (w_gnt[N_RD]) begin
      w_sel_addr = wr_addr;
    end
  end

  // Command stage: the tag rides alongside so the return can be steered later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_strb  <= '0;
      r_tag_cmd   <= '0;
      r_tag_ret   <= '0;
    end else begin
      r_mem_en          <= w_any_gnt;
      r_mem_we          <= w_is_wr;
      r_mem_addr        <= w_sel_addr;
      r_mem_wdata       <= w_is_wr ? wr_data : '0;
      r_mem_strb        <= w_is_wr ? wr_strb : '0;
      r_tag_cmd.valid   <= w_any_gnt;
      r_tag_cmd.idx     <= TAG_IDX_W'(w_gnt_idx);
      r_tag_cmd.is_read <= w_any_gnt & ~w_is_wr;
      r_tag_ret         <= r_tag_cmd;
    end
  end

  // Return stage: mem_rdata lines up with r_tag_ret.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_rvalid <= '0;
      r_rd_data   <= '0;
    end else begin
      r_rd_rvalid <= '0;
      for (int i = 0; i < N_RD; i++) begin
        if (r_tag_ret.valid && r_tag_ret.is_read && (int'(r_tag_ret.idx) == i)) begin
          r_rd_rvalid[i]                       <= 1'b1;
          r_rd_data[i*AXI_WIDTH +: AXI_WIDTH]  <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_strb  = r_mem_strb;
  assign rd_rvalid = r_rd_rvalid;
  assign rd_data   = r_rd_data;

`ifdef MEM_ARB_PERF_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_perf
    logic [31:0] r_gnt_cnt;
    logic [31:0] r_wait_cnt;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_gnt_cnt  <= '0;
        r_wait_cnt <= '0;
      end else begin
        if (w_gnt[g] && (r_gnt_cnt != '1)) begin
          r_gnt_cnt <= r_gnt_cnt + 32'd1;
        end
        if (w_req[g] && !w_gnt[g] && (r_wait_cnt != '1)) begin
          r_wait_cnt <= r_wait_cnt + 32'd1;
        end
      end
    end

    assign perf_gnt_cnt[g*32 +: 32]  = r_gnt_cnt;
    assign perf_wait_cnt[g*32 +: 32] = r_wait_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed stimulus with a queue-based reference |
// |   model checked every cycle. Rev 1.0                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int W    = 128;
  localparam int AW   = 28;
  localparam int SW   = 16;
  localparam int NRD  = 3;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NRD-1:0]    rd_req;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD-1:0]    rd_gnt;
  logic [NRD-1:0]    rd_rvalid;
  logic [NRD*W-1:0]  rd_data;
  logic              wr_req;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic [SW-1:0]     wr_strb;
  logic              wr_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [W-1:0]      mem_wdata;
  logic [SW-1:0]     mem_strb;
  logic [W-1:0]      mem_rdata;

  mem_port_arbiter dut (
    .clk       (clk),
    .rstn      (rstn),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_rvalid (rd_rvalid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_gnt    (wr_gnt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_strb  (mem_strb),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: actual=%h required=%h", nm, cyc, act, exp);
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [SW-1:0] s);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] init_word(input int i);
    if (i == 16) return {16{8'hA5}};
    return {4{32'hC0DE0000 + 32'(i)}};
  endfunction

  // Memory attached to the DUT: registered read, byte-masked write.
  logic [W-1:0] ram [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[5:0]] = merge(ram[mem_addr[5:0]], mem_wdata, mem_strb);
      else        mem_rdata <= ram[mem_addr[5:0]];
    end
  end

  // Reference model: memory updated in grant order, returns due 3 cycles after grant.
  typedef struct {
    int           port;
    logic [W-1:0] data;
    int           due;
  } ret_t;

  ret_t          rq[$];
  int            m_ptr = NREQ - 1;
  logic [W-1:0]  m_mem [64];
  logic [W-1:0]  m_rdd [NRD];
  logic          e_en = 1'b0, e_we = 1'b0, e_full = 1'b1;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0]  e_wdata = '0;
  logic [SW-1:0] e_strb = '0;

  always @(negedge clk) begin
    logic [NRD-1:0]  e_rv;
    logic [NREQ-1:0] reqv;
    logic [NREQ-1:0] e_g;
    int              g;
    if (cyc >= 1) begin
      e_rv = '0;
      while (rq.size() > 0 && rq[0].due == cyc) begin
        e_rv[rq[0].port]  = 1'b1;
        m_rdd[rq[0].port] = rq[0].data;
        void'(rq.pop_front());
      end
      reqv = {wr_req, rd_req};
      e_g  = '0;
      g    = -1;
      if (rstn) begin
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && reqv[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      if (g >= 0) e_g[g] = 1'b1;

      check("grant", W'({wr_gnt, rd_gnt}), W'(e_g));
      check("mem_en", W'(mem_en), W'(e_en));
      if (e_en || e_full) begin
        check("mem_we", W'(mem_we), W'(e_we));
        check("mem_addr", W'(mem_addr), W'(e_addr));
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_strb", W'(mem_strb), W'(e_strb));
      end
      check("rd_rvalid", W'(rd_rvalid), W'(e_rv));
      for (int p = 0; p < NRD; p++) check("rd_data", rd_data[p*W +: W], m_rdd[p]);

      if (!rstn) begin
        m_ptr = NREQ - 1;
        e_en = 1'b0; e_we = 1'b0; e_full = 1'b1;
        e_addr = '0; e_wdata = '0; e_strb = '0;
        rq.delete();
        for (int p = 0; p < NRD; p++) m_rdd[p] = '0;
      end else if (g >= 0) begin
        m_ptr  = g;
        e_en   = 1'b1;
        e_full = 1'b1;
        e_we   = (g == NRD);
        if (g == NRD) begin
          e_addr  = wr_addr;
          e_wdata = wr_data;
          e_strb  = wr_strb;
          m_mem[wr_addr[5:0]] = merge(m_mem[wr_addr[5:0]], wr_data, wr_strb);
        end else begin
          e_addr  = rd_addr[g*AW +: AW];
          e_wdata = '0;
          e_strb  = '0;
          rq.push_back('{port: g, data: m_mem[e_addr[5:0]], due: cyc + 3});
        end
      end else begin
        e_en   = 1'b0;
        e_full = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  logic [3:0] seq [4];

  initial begin
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 64; i++) begin
      ram[i]   = init_word(i);
      m_mem[i] = init_word(i);
    end
    for (int p = 0; p < NRD; p++) m_rdd[p] = '0;
    mem_rdata = '0;

    // Reset with everyone requesting.
    rstn    = 1'b0;
    rd_req  = '1;
    rd_addr = '0;
    set_raddr(0, 28'h1); set_raddr(1, 28'h2); set_raddr(2, 28'h3);
    wr_req  = 1'b1;
    wr_addr = 28'h30;
    wr_data = {4{32'hDEADBEEF}};
    wr_strb = '1;
    step();
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", W'({wr_gnt, rd_gnt}), W'(0));
      check("rst_mem_en", W'(mem_en), W'(0));
      check("rst_rvalid", W'(rd_rvalid), W'(0));
      step();
    end
    rstn = 1'b1;

    // Full contention: strict rotation 0,1,2,W with the memory busy every cycle.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_seq", W'({wr_gnt, rd_gnt}), W'(seq[k % 4]));
      if (k > 0) check("rr_busy", W'(mem_en), W'(1));
      step();
    end
    rd_req = '0; wr_req = 1'b0;
    repeat (4) step();

    // Lone requester held high wins every cycle.
    set_raddr(2, 28'h5);
    rd_req = 3'b100;
    repeat (3) begin
      @(negedge clk);
      check("hold_gnt", W'(rd_gnt), W'(3'b100));
      step();
    end
    rd_req = '0;
    repeat (3) step();

    // Single read of word 0x10.
    set_raddr(1, 28'h10);
    rd_req = 3'b010;
    @(negedge clk);
    check("rd1_gnt", W'(rd_gnt), W'(3'b010));
    step();
    rd_req = '0;
    @(negedge clk);
    check("rd1_en", W'(mem_en), W'(1));
    check("rd1_we", W'(mem_we), W'(0));
    check("rd1_addr", W'(mem_addr), W'(28'h10));
    step(); step();
    @(negedge clk);
    check("rd1_rvalid", W'(rd_rvalid), W'(3'b010));
    check("rd1_data", rd_data[1*W +: W], {16{8'hA5}});
    step();

    // Write then read-after-write at the same address.
    wr_req  = 1'b1;
    wr_addr = 28'h20;
    wr_data = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    wr_strb = '1;
    @(negedge clk);
    check("raw_wgnt", W'(wr_gnt), W'(1));
    step();
    wr_req = 1'b0;
    set_raddr(0, 28'h20);
    rd_req = 3'b001;
    @(negedge clk);
    check("raw_rgnt", W'(rd_gnt), W'(3'b001));
    step();
    rd_req = '0;
    step(); step();
    @(negedge clk);
    check("raw_rvalid", W'(rd_rvalid), W'(3'b001));
    check("raw_data", rd_data[0 +: W], 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    step();

    // Byte-0-only write to word 0, then read it back.
    wr_req  = 1'b1;
    wr_addr = 28'h0;
    wr_data = 128'hFF;
    wr_strb = 16'h0001;
    @(negedge clk);
    check("ps_wgnt", W'(wr_gnt), W'(1));
    step();
    wr_req = 1'b0;
    set_raddr(2, 28'h0);
    rd_req = 3'b100;
    @(negedge clk);
    check("ps_we", W'(mem_we), W'(1));
    check("ps_strb", W'(mem_strb), W'(16'h0001));
    check("ps_wdata", mem_wdata, 128'hFF);
    check("ps_rgnt", W'(rd_gnt), W'(3'b100));
    step();
    rd_req = '0;
    step(); step();
    @(negedge clk);
    check("ps_rvalid", W'(rd_rvalid), W'(3'b100));
    check("ps_data", rd_data[2*W +: W], {32'hC0DE0000, 32'hC0DE0000, 32'hC0DE0000, 32'hC0DE00FF});
    step();

    // Reset while a read is in flight.
    set_raddr(0, 28'h10);
    rd_req = 3'b001;
    @(negedge clk);
    check("mf_gnt", W'(rd_gnt), W'(3'b001));
    step();
    rd_req = '0;
    rstn   = 1'b0;
    @(negedge clk);
    check("mf_rst_gnt", W'({wr_gnt, rd_gnt}), W'(0));
    step();
    rstn   = 1'b1;
    rd_req = '1;
    wr_req = 1'b1;
    @(negedge clk);
    check("mf_rvalid2", W'(rd_rvalid), W'(0));
    check("mf_ptr", W'({wr_gnt, rd_gnt}), W'(4'b0001));
    step();
    rd_req = '0;
    wr_req = 1'b0;
    @(negedge clk);
    check("mf_rvalid3", W'(rd_rvalid), W'(0));
    step();
    @(negedge clk);
    check("mf_rvalid4", W'(rd_rvalid), W'(0));
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port word memory between three mm2s read requesters and one s2mm write requester of top_ram.
- Word-addressed memory-side interface: en/we/addr/wdata/strb out, registered rdata in; same signalling as the testbench memory model.
- Round-robin arbitration, one grant per cycle, in-order registered command pipeline, per-port held read data with a valid pulse.

Parameters:
- AXI_WIDTH, 128, data word width in bits; multiple of 8.
- AXI_ADDR_WIDTH, 32, byte address width; word address width AW = AXI_ADDR_WIDTH - LSB, where LSB = $clog2(AXI_WIDTH)-3.
- N_RD, 3, number of read requesters; requester index N_RD is the writer.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset, sampled on posedge clk.
- rd_req  in  N_RD  read request per port.
- rd_addr  in  N_RD*AW  word address per port, packed, port i at [i*AW +: AW].
- rd_gnt  out  N_RD  combinational grant, one-hot with wr_gnt.
- rd_rvalid  out  N_RD  one-cycle pulse: rd_data of port i updated.
- rd_data  out  N_RD*AXI_WIDTH  per-port held read data.
- wr_req  in  1  write request.
- wr_addr  in  AW  word address.
- wr_data  in  AXI_WIDTH  write data.
- wr_strb  in  AXI_WIDTH/8  byte enables.
- wr_gnt  out  1  combinational write grant.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  write when 1, read when 0.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  AXI_WIDTH  memory write data.
- mem_strb  out  AXI_WIDTH/8  memory byte enables.
- mem_rdata  in  AXI_WIDTH  read data; valid in the cycle after the mem_en read cycle.

Behaviour:
- Requesters 0..N_RD-1 are readers, N_RD is the writer (NREQ = N_RD+1).
- A requester holds req, addr and wdata/strb stable until granted.
- Dropping req before grant is legal; the request is withdrawn.
- Arbitration:
  - Combinational round-robin over NREQ using last-grant pointer ptr.
  - Search starts at ptr+1 mod NREQ.
  - At most one grant per cycle.
  - Grant implies req in the same cycle.
  - ptr updates to the granted index at the clock edge; unchanged when there is no grant.
- Command stage (cycle t grant → cycle t+1):
  - mem_en, mem_we, mem_addr, mem_wdata, mem_strb registered from the granted requester.
  - mem_en=0 when no grant at t.
  - mem_wdata and mem_strb forced to 0 for reads.
  - A registered tag (valid, port index, is_read) travels with the command.
- Return stage:
  - Tag delayed one more cycle; mem_rdata is valid in t+2.
  - For a read tag, rd_data[port] captures mem_rdata at the end of t+2.
  - rd_rvalid[port] pulses high exactly in t+3.
  - Read latency grant→rvalid is 3 cycles.
  - rd_data of other ports holds.
  - Write grants produce no return.
- Throughput: a new grant is possible every cycle; pipeline never stalls (memory always accepts).
- Ordering is strictly grant order. A read granted the cycle after a write to the same address returns the new data.
- A single requester held high is granted every cycle.
- All requesters high: grants rotate 0,1,2,W,0,…
- Reset values (rstn=0 at an edge):
  - ptr=NREQ-1, so reader 0 has first priority.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_strb=0.
  - Tags invalid, rd_rvalid=0, rd_data=0.
  - Grants are forced 0 while rstn=0.
- Reset mid-operation: in-flight reads are dropped; no rvalid is issued for them after reset.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds outputs perf_gnt_cnt (NREQ*32) and perf_wait_cnt (NREQ*32).
  - Per requester: grant count, and count of cycles with req high and no gnt.
  - 32-bit saturating, cleared by reset.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - NREQ derivation helper.
  - LSB/AW computation functions.
  - Typedef arb_tag_t {valid, idx[$clog2(NREQ)-1:0], is_read}.
- One sub-module, rr_arbiter:
  - Parameterised NREQ.
  - req vector in, one-hot gnt out, internal ptr register.
  - Synchronous active-low rstn.
- Parent holds the command and return pipeline.

Test Plan:
- Reset: rstn=0 for 2 cycles with all req=1 → all gnt=0, mem_en=0, rd_rvalid=0. First gnt after release goes to rd 0.
- Single read: rd_req[1]=1, addr=0x10 at t, memory word 0x10 = 0xA5…A5 → rd_gnt[1] at t; mem_en=1, mem_we=0, mem_addr=0x10 at t+1; rd_rvalid[1] at t+3 with rd_data[1]=0xA5…A5; rd_data[0], rd_data[2] unchanged.
- Contention: all four req held for 8 cycles → grant sequence 0,1,2,W,0,1,2,W, one per cycle, with no idle mem_en cycles.
- Write-then-read: write addr 0x20, data 0x1234…, strb all-ones, granted t; rd 0 reads 0x20, granted t+1 → rd_data[0]=written value at t+4.
- Partial strobe: wr_strb=0x0001, data byte0=0xFF on word 0 → mem_strb=0x0001, mem_wdata=0x…FF at t+1; read back shows only byte0 changed.
- Reset mid-flight: grant a read at t, rstn=0 at t+1 → no rd_rvalid in t+2..t+4; ptr back at reset value.
